// File: rtl/sm4_sched_pkg.sv
// Shared types and helpers for the SM4 lane scheduler: FSM state encoding,
// lane one-hot decode, power-level to lane index mapping and a group-index min.
package sm4_sched_pkg;

  // Upper bounds used to size the helper functions independently of the
  // scheduler parameters; callers cast in and out of these widths.
  localparam int MAX_LANES = 7;
  localparam int MAX_GW    = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_WAIT     = 3'd2,
    S_OUTPUT   = 3'd3,
    S_FIN      = 3'd4
  } sched_state_t;

  // One-hot decode of a lane index (0..6).
  function automatic logic [MAX_LANES-1:0] lane_onehot(input logic [2:0] idx);
    logic [7:0] wide;
    wide = 8'd1 << idx;
    return wide[MAX_LANES-1:0];
  endfunction

  // Power level k selects lane k-1; only meaningful for k >= 1.
  function automatic logic [2:0] level_to_lane(input logic [7:0] level);
    logic [7:0] idx;
    idx = level - 8'd1;
    return idx[2:0];
  endfunction

  // True when the level names an existing lane (1..n_lanes).
  function automatic logic level_is_lane(input logic [7:0] level, input int n_lanes);
    return (level != 8'd0) && (int'(level) <= n_lanes);
  endfunction

  // Unsigned minimum of two group indices.
  function automatic logic [MAX_GW-1:0] grp_min(input logic [MAX_GW-1:0] a,
                                                input logic [MAX_GW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/sm4_lane_sched.sv
// SM4 lane scheduler: hands a job of total_groups groups out, one round at a
// time, to whichever external SM4 engine lane pwr_level selects, collects the
// round result and presents it downstream before dispatching the next round.
//
// Handshake: dout is offered while dout_vld=1 and is held stable until a cycle
// with dout_vld=1 and dout_rdy=1; that cycle is the transfer and dout_vld drops
// on the following edge. No new round is dispatched until the transfer.
//
// Timing: every output except busy is registered, so lane_start appears two
// cycles after start is sampled, and dout_vld one cycle after lane_rdy.
module sm4_lane_sched
  import sm4_sched_pkg::*;
#(
  parameter int N_LANES = 3,
  parameter int DW      = 384,
  parameter int GW      = 32,
  parameter int LW      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [GW-1:0]         total_groups,
  input  logic [LW-1:0]         pwr_level,
  output logic [N_LANES-1:0]    lane_start,
  output logic [GW-1:0]         lane_grp,
  input  logic [N_LANES-1:0]    lane_rdy,
  input  logic [N_LANES*GW-1:0] lane_next,
  input  logic [N_LANES*DW-1:0] lane_dout,
  output logic [DW-1:0]         dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  sched_state_t state_q, state_d;

  logic [GW-1:0]      total_q, total_d;
  logic [GW-1:0]      next_grp_q, next_grp_d;
  logic [GW-1:0]      lane_grp_q, lane_grp_d;
  logic [2:0]         act_q, act_d;
  logic [N_LANES-1:0] lane_start_q, lane_start_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Decoded views of the active lane and the requested level.
  logic [N_LANES-1:0] act_mask;
  logic [GW-1:0]      act_next;
  logic [DW-1:0]      act_dout;
  logic [7:0]         level_w;
  logic               level_ok;
  logic               act_rdy;
  logic               stray_rdy;

  // Select the active lane's slices and classify the incoming pulses.
  always_comb begin
    act_mask  = N_LANES'(lane_onehot(act_q));
    act_next  = GW'(lane_next >> (int'(act_q) * GW));
    act_dout  = DW'(lane_dout >> (int'(act_q) * DW));
    level_w   = 8'(pwr_level);
    level_ok  = level_is_lane(level_w, N_LANES);
    act_rdy   = |(lane_rdy & act_mask);
    stray_rdy = |(lane_rdy & ~act_mask);
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    next_grp_d   = next_grp_q;
    lane_grp_d   = lane_grp_q;
    act_d        = act_q;
    lane_start_d = '0;
    dout_d       = dout_q;
    dout_vld_d   = dout_vld_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d    = total_groups;
          next_grp_d = '0;
          err_d      = 1'b0;
          state_d    = (total_groups == '0) ? S_FIN : S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        // Level 0 pauses; an out-of-range level flags an error and also waits
        // for a usable level, so software can recover without a reset.
        if (level_w != 8'd0) begin
          if (!level_ok) begin
            err_d = 1'b1;
          end else begin
            act_d        = level_to_lane(level_w);
            lane_start_d = N_LANES'(lane_onehot(level_to_lane(level_w)));
            lane_grp_d   = next_grp_q;
            state_d      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (stray_rdy) begin
          err_d = 1'b1;
        end
        if (act_rdy) begin
          dout_d     = act_dout;
          dout_vld_d = 1'b1;
          state_d    = S_OUTPUT;
          // A lane that fails to advance would loop forever; end the job.
          if (act_next <= next_grp_q) begin
            err_d      = 1'b1;
            next_grp_d = total_q;
          end else begin
            next_grp_d = GW'(grp_min(MAX_GW'(act_next), MAX_GW'(total_q)));
          end
        end
      end

      S_OUTPUT: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          state_d    = (next_grp_q >= total_q) ? S_FIN : S_DISPATCH;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      total_q      <= '0;
      next_grp_q   <= '0;
      lane_grp_q   <= '0;
      act_q        <= '0;
      lane_start_q <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      next_grp_q   <= next_grp_d;
      lane_grp_q   <= lane_grp_d;
      act_q        <= act_d;
      lane_start_q <= lane_start_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign lane_start = lane_start_q;
  assign lane_grp   = lane_grp_q;
  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sm4_lane_sched.sv
// Self-checking bench for sm4_lane_sched. The bench plays the external engine
// lanes and the downstream consumer; a job-level reference model (group
// progress, clamp, error and done rules) supplies every expected value.
module tb_sm4_lane_sched;

  localparam int N  = 3;
  localparam int DW = 384;
  localparam int GW = 32;
  localparam int LW = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start;
  logic [GW-1:0]     total_groups;
  logic [LW-1:0]     pwr_level;
  logic [N-1:0]      lane_start;
  logic [GW-1:0]     lane_grp;
  logic [N-1:0]      lane_rdy;
  logic [N*GW-1:0]   lane_next;
  logic [N*DW-1:0]   lane_dout;
  logic [DW-1:0]     dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  sm4_lane_sched #(.N_LANES(N), .DW(DW), .GW(GW), .LW(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .total_groups (total_groups),
    .pwr_level    (pwr_level),
    .lane_start   (lane_start),
    .lane_grp     (lane_grp),
    .lane_rdy     (lane_rdy),
    .lane_next    (lane_next),
    .lane_dout    (lane_dout),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .dout_rdy     (dout_rdy),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Scoreboard and job-level reference model
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int m_total;
  int m_next;
  bit m_err;

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Accept a job; leaves the bench at the negedge before the first dispatch.
  task automatic start_job(input int total, input int lvl);
    start        = 1'b1;
    total_groups = GW'(total);
    pwr_level    = LW'(lvl);
    step();
    start   = 1'b0;
    m_total = total;
    m_next  = 0;
    m_err   = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || lane_start !== '0) begin
      errors++;
      $display("FAIL start_accept: err=%b busy=%b lane_start=%b, want err=0 busy=1 lane_start=0",
               err, busy, lane_start);
    end
  endtask

  // One full round on lane lvl-1: dispatch, engine reply with group index
  // nxt, optional stray pulse from lane foreign-1, and the output handshake
  // with hold cycles of back-pressure (negative hold means random).
  task automatic do_round(input int lvl, input int nxt, input int foreign,
                          input int hold, output bit last);
    int idx;
    int dly;
    int hcnt;
    logic [N-1:0] exp_ls;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] held;

    idx       = lvl - 1;
    exp_ls    = '0;
    exp_ls[idx] = 1'b1;
    pwr_level = LW'(lvl);
    step();
    checks++;
    if (lane_start !== exp_ls) begin
      errors++;
      $display("FAIL lane_start: got %b want %b", lane_start, exp_ls);
    end
    checks++;
    if (lane_grp !== GW'(m_next)) begin
      errors++;
      $display("FAIL lane_grp: got %0d want %0d", lane_grp, m_next);
    end

    // Level changes while the round is in flight must not matter.
    pwr_level = LW'($urandom_range(0, 7));

    if (foreign != 0) begin
      lane_rdy = '0;
      lane_rdy[foreign-1] = 1'b1;
      step();
      lane_rdy = '0;
      m_err = 1'b1;
      checks++;
      if (dout_vld !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL stray_rdy: dout_vld=%b err=%b, want dout_vld=0 err=1", dout_vld, err);
      end
    end

    dly = $urandom_range(0, 3);
    for (int i = 0; i < dly; i++) begin
      start        = 1'($urandom_range(0, 1));
      total_groups = GW'($urandom);
      step();
      checks++;
      if (lane_start !== '0 || dout_vld !== 1'b0) begin
        errors++;
        $display("FAIL wait_quiet: lane_start=%b dout_vld=%b, want 0 0", lane_start, dout_vld);
      end
    end
    start = 1'b0;

    for (int j = 0; j < N; j++) begin
      lane_dout[j*DW +: DW] = rand_dw();
      lane_next[j*GW +: GW] = GW'($urandom);
    end
    exp_d = rand_dw();
    lane_dout[idx*DW +: DW] = exp_d;
    lane_next[idx*GW +: GW] = GW'(nxt);
    exp_q.push_back(exp_d);
    lane_rdy = '0;
    lane_rdy[idx] = 1'b1;
    step();
    lane_rdy = '0;

    if (nxt <= m_next) begin
      m_err  = 1'b1;
      m_next = m_total;
    end else begin
      m_next = (nxt < m_total) ? nxt : m_total;
    end

    held = exp_q.pop_front();
    checks++;
    if (dout_vld !== 1'b1 || dout !== held) begin
      errors++;
      $display("FAIL capture: dout_vld=%b dout=%h want dout_vld=1 dout=%h", dout_vld, dout, held);
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL err_after_round: got %b want %b", err, m_err);
    end

    hcnt = (hold < 0) ? $urandom_range(0, 4) : hold;
    for (int i = 0; i < hcnt; i++) begin
      pwr_level = LW'($urandom_range(0, 7));
      lane_dout[idx*DW +: DW] = rand_dw();
      step();
      checks++;
      if (dout_vld !== 1'b1 || dout !== held || lane_start !== '0) begin
        errors++;
        $display("FAIL backpressure: dout_vld=%b lane_start=%b dout=%h want vld=1 ls=0 dout=%h",
                 dout_vld, lane_start, dout, held);
      end
    end

    dout_rdy = 1'b1;
    step();
    dout_rdy = 1'b0;
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL transfer_drop: dout_vld=%b want 0", dout_vld);
    end
    last = (m_next >= m_total);
  endtask

  // Expect the FIN cycle, a single done pulse, then idle.
  task automatic finish_job();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fin_state: done=%b busy=%b want done=0 busy=1", done, busy);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== m_err) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b err=%b want done=1 busy=0 err=%b",
               done, busy, err, m_err);
    end
    step();
    checks++;
    if (done !== 1'b0 || lane_start !== '0) begin
      errors++;
      $display("FAIL done_single: done=%b lane_start=%b want 0 0", done, lane_start);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (lane_start !== '0 || lane_grp !== '0 || dout !== '0 || dout_vld !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ls=%b grp=%0d vld=%b busy=%b done=%b err=%b want all 0",
               lane_start, lane_grp, dout_vld, busy, done, err);
    end
  endtask

  task automatic test_basic();
    bit last;
    start_job(6, 1);
    do_round(1, 3, 0, -1, last);
    checks++;
    if (last !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_round1: last=%b busy=%b want 0 1", last, busy);
    end
    do_round(1, 6, 0, -1, last);
    checks++;
    if (last !== 1'b1) begin
      errors++;
      $display("FAIL basic_round2: last=%b want 1", last);
    end
    finish_job();
  endtask

  task automatic test_level_switch();
    bit last;
    start_job(9, 1);
    do_round(1, 3, 0, -1, last);
    do_round(3, 6, 0, -1, last);
    do_round(2, 9, 0, -1, last);
    checks++;
    if (last !== 1'b1) begin
      errors++;
      $display("FAIL switch_end: last=%b want 1", last);
    end
    finish_job();
  endtask

  task automatic test_pause();
    bit last;
    start_job(2, 0);
    pwr_level = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (lane_start !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pause: lane_start=%b busy=%b want 0 1", lane_start, busy);
      end
    end
    do_round(2, 2, 0, -1, last);
    finish_job();
  endtask

  task automatic test_backpressure();
    bit last;
    start_job(4, 2);
    do_round(2, 2, 0, 5, last);
    do_round(1, 4, 0, 5, last);
    finish_job();
  endtask

  task automatic test_total_zero();
    start_job(0, 1);
    finish_job();
  endtask

  task automatic test_bad_level();
    bit last;
    start_job(4, 5);
    pwr_level = LW'(5);
    step();
    checks++;
    if (err !== 1'b1 || lane_start !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_level5: err=%b ls=%b busy=%b want 1 0 1", err, lane_start, busy);
    end
    pwr_level = LW'(4);
    step();
    checks++;
    if (err !== 1'b1 || lane_start !== '0) begin
      errors++;
      $display("FAIL bad_level4: err=%b ls=%b want 1 0", err, lane_start);
    end
    m_err = 1'b1;
    do_round(1, 4, 0, -1, last);
    finish_job();
    // A new accepted start clears the sticky flag (checked in start_job).
    start_job(3, 3);
    do_round(3, 3, 0, -1, last);
    finish_job();
  endtask

  task automatic test_bad_next();
    bit last;
    start_job(10, 1);
    do_round(1, 4, 0, -1, last);
    do_round(2, 0, 0, -1, last);
    checks++;
    if (last !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_next: last=%b err=%b want 1 1", last, err);
    end
    finish_job();
  endtask

  task automatic test_stray_rdy();
    bit last;
    start_job(5, 1);
    do_round(1, 7, 3, -1, last);
    finish_job();
  endtask

  task automatic test_reset_mid();
    start_job(9, 1);
    pwr_level = LW'(1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (lane_start !== '0 || lane_grp !== '0 || dout !== '0 || dout_vld !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ls=%b vld=%b busy=%b done=%b err=%b want all 0",
               lane_start, dout_vld, busy, done, err);
    end
    lane_next[0 +: GW] = GW'(3);
    lane_dout[0 +: DW] = rand_dw();
    lane_rdy = 3'b001;
    step();
    lane_rdy = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lane_start !== '0) begin
        errors++;
        $display("FAIL late_rdy: vld=%b busy=%b done=%b ls=%b want all 0",
                 dout_vld, busy, done, lane_start);
      end
      step();
    end
  endtask

  task automatic test_random();
    bit last;
    int nxt;
    int r;
    int rounds;
    for (int job = 0; job < 8; job++) begin
      start_job($urandom_range(1, 20), 1);
      last   = 1'b0;
      rounds = 0;
      while (!last && rounds < 40) begin
        r = $urandom_range(0, 9);
        if (r == 0) nxt = m_next;
        else if (r == 1) nxt = m_next + 50;
        else nxt = m_next + $urandom_range(1, 6);
        do_round($urandom_range(1, 3), nxt, 0, -1, last);
        rounds++;
      end
      checks++;
      if (!last) begin
        errors++;
        $display("FAIL random_budget: job %0d not finished after %0d rounds", job, rounds);
      end
      finish_job();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    total_groups = '0;
    pwr_level    = '0;
    lane_rdy     = '0;
    lane_next    = '0;
    lane_dout    = '0;
    dout_rdy     = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_level_switch();
    test_pause();
    test_backpressure();
    test_total_zero();
    test_bad_level();
    test_bad_next();
    test_stray_rdy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_lane_sched.md
SM4_LANE_SCHED -- requirements
Module: sm4_lane_sched

Interface
REQ-001 Parameter N_LANES, default 3, is the number of external SM4 engine lanes (1..7).
REQ-002 Parameter DW, default 384, is the data block width per round.
REQ-003 Parameter GW, default 32, is the group-counter width.
REQ-004 Parameter LW, default 3, is the power-level width; it SHALL satisfy 2**LW > N_LANES.
REQ-005 Port clk, input, 1, is the clock; all logic SHALL be rising-edge.
REQ-006 Port rst_n, input, 1, is the reset: synchronous, active-low.
REQ-007 Port start, input, 1, requests a job; it is sampled only in IDLE.
REQ-008 Port total_groups, input, GW, is the job length in groups; it is latched on accepted start.
REQ-009 Port pwr_level, input, LW, selects the lane: 0 = pause, k = lane k-1.
REQ-010 Port lane_start, output, N_LANES, carries one-hot single-cycle lane start pulses.
REQ-011 Port lane_grp, output, GW, is the first group index for the started lane; it is shared by all lanes.
REQ-012 Port lane_rdy, input, N_LANES, carries per-lane round-complete pulses.
REQ-013 Port lane_next, input, N_LANES*GW, is the per-lane next group index (lane i at bits [i*GW +: GW]).
REQ-014 Port lane_dout, input, N_LANES*DW, is the per-lane round result.
REQ-015 Port dout, output, DW, is the captured round result.
REQ-016 Port dout_vld, output, 1, is the output valid; it follows valid/ready rules.
REQ-017 Port dout_rdy, input, 1, is the downstream ready.
REQ-018 Port busy, output, 1, is high in every state except IDLE.
REQ-019 Port done, output, 1, is a single-cycle job-complete pulse.
REQ-020 Port err, output, 1, is a sticky protocol/level error flag; it is cleared only by reset or an accepted start.

Function
REQ-021 The FSM SHALL have states IDLE, DISPATCH, WAIT, OUTPUT, FIN.
REQ-022 In IDLE, start=1 SHALL latch total_groups, set next_grp=0, clear err, and go to DISPATCH; if total_groups=0, it SHALL go to FIN instead.
REQ-023 In DISPATCH with pwr_level=0, the block SHALL hold (pause) with no lane_start.
REQ-024 In DISPATCH with pwr_level>N_LANES, the block SHALL set err and hold.
REQ-025 In DISPATCH with a valid level k, the block SHALL pulse lane_start[k-1] for exactly one cycle with lane_grp=next_grp, record act=k-1, and go to WAIT.
REQ-026 In WAIT, only lane_rdy[act] SHALL be honoured; pulses from other lanes SHALL be ignored and SHALL set err.
REQ-027 On lane_rdy[act], the block SHALL capture lane_dout slice act into dout, set next_grp=min(lane_next slice act, total), set dout_vld=1 the next cycle, and go to OUTPUT.
REQ-028 If the captured lane_next is less than or equal to the old next_grp, the block SHALL set err and force next_grp=total, so the job terminates.
REQ-029 In OUTPUT, dout and dout_vld SHALL be held stable until dout_rdy=1; the transfer cycle SHALL drop dout_vld.
REQ-030 After the transfer, the block SHALL go to FIN if next_grp>=total, else to DISPATCH.
REQ-031 pwr_level SHALL be re-evaluated each DISPATCH, so consecutive rounds may use different lanes; the lane switch SHALL continue from next_grp.
REQ-032 In FIN, the block SHALL pulse done for one cycle and return to IDLE.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 pwr_level changes during WAIT/OUTPUT SHALL have no effect until the next DISPATCH.
REQ-035 Dispatch latency from start to lane_start SHALL be 2 cycles; from lane_rdy to dout_vld, 1 cycle.

Reset
REQ-036 Reset SHALL force state=IDLE, all outputs 0 (lane_start, lane_grp, dout, dout_vld, busy, done, err), next_grp=0, act=0.
REQ-037 Reset asserted mid-job SHALL abandon the job without a done pulse; lane_rdy pulses arriving after reset SHALL be ignored.

Structure
REQ-038 Package sm4_sched_pkg SHALL hold the state enum and the lane-select/min helper functions.
REQ-039 The design SHALL be a single module with no sub-modules; the engines remain external.

Verification
REQ-040 With N=3, total=6, level=1, a lane0 model advancing 3 per round: 2 rounds, dout values in order, 1 done pulse, err=0.
REQ-041 Switching level 1->3 between rounds with total=9: round 2 goes to lane2 with lane_grp=3, and the job completes at next_grp=9.
REQ-042 level=0 for 10 cycles in DISPATCH: no lane_start; after level=2, lane_start=3'b010 follows the next cycle.
REQ-043 dout_rdy low for 5 cycles: dout/dout_vld stable, no new lane_start.
REQ-044 Cases: total=0 gives done 2 cycles after start; level=5 sets err; lane_next=0 sets err and terminates with done.
REQ-045 rst_n low during WAIT: all outputs 0 next cycle, and a later lane_rdy is ignored.
